imem_port_arbiter: RTL
======================

Name: imem_port_arbiter

Overview:
- Shares the single-port 1024x32 instruction memory between two requesters: the core fetch unit (read-only) and the boot/debug loader (read/write).
- Pipelined. At most one grant per cycle; read data returns exactly 1 cycle after grant.
- Sits between the fetch stage, the loader, and the instruction memory macro.
- Priority is loader first, with an anti-starvation guarantee for fetch.

Parameters:
- DEPTH, 1024, memory depth in 32-bit words. Must be a power of 2.
- AW, 10, word-index width. Equals log2(DEPTH).
- STARVE_MAX, 4, maximum consecutive loader grants while fetch is waiting before fetch is forced.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- f_valid  in  1  fetch request valid
- f_ready  out  1  fetch request accepted this cycle
- f_addr  in  32  fetch byte address
- f_rvalid  out  1  fetch response valid
- f_rdata  out  32  fetch read data
- f_err  out  1  fetch response error, qualified by f_rvalid
- l_valid  in  1  loader request valid
- l_ready  out  1  loader request accepted
- l_we  in  1  loader write (1) or read (0)
- l_addr  in  32  loader byte address
- l_wdata  in  32  loader write data
- l_rvalid  out  1  loader response valid; fires for reads and writes
- l_rdata  out  32  loader read data; 0 for writes
- l_err  out  1  loader response error
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset values:
  - All outputs 0.
  - Starvation counter 0.
  - Response pipeline register empty.
- Reset during operation: an in-flight response is dropped; no rvalid pulse follows reset.
- Handshake:
  - A request transfers on valid & ready in the same cycle.
  - ready is combinational from valid and the arbitration state.
  - Requesters hold valid and all request fields stable until ready.
  - Responses have no backpressure.
- Arbitration, evaluated each cycle:
  - Only l_valid set: grant loader.
  - Only f_valid set: grant fetch.
  - Both set: grant loader, unless starve_cnt == STARVE_MAX, in which case grant fetch.
  - starve_cnt increments on each loader grant while f_valid=1 and fetch is not granted; saturates at STARVE_MAX.
  - starve_cnt clears on any fetch grant, or on any cycle with f_valid=0.
- Address checks on the granted request:
  - Error if addr[1:0] != 0 (misaligned) or addr[31:2] >= DEPTH (out of range).
  - Error requests are still accepted (ready=1), but mem_en=0.
  - The response arrives 1 cycle later with err=1 and rdata=0.
- Memory drive in the grant cycle:
  - mem_en=1 for a legal request.
  - mem_we = l_we for loader, 0 for fetch.
  - mem_addr = addr[AW+1:2].
  - mem_wdata = l_wdata, else 0.
- Response stage:
  - A 1-deep register holds owner ID, error flag and write flag.
  - Cycle N+1 after grant: the owner's rvalid=1 and rdata = mem_rdata (0 on error or write).
  - The non-owner's rvalid=0.
- Throughput: back-to-back grants every cycle, alternating requesters allowed, with no bubble.
- Write then read of the same word (loader write in cycle N, any read in N+1): the read returns the new data. The memory is write-first, which is the memory's contract; no forwarding is required in this block.

Optional Feature:
- Macro: IMEM_ARB_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - lock is sampled at a loader write grant. If lock=1, the write is accepted but suppressed (mem_en=0), and the response returns l_err=1.
  - Loader reads and fetch are unaffected.
- When undefined: no lock port, and loader writes are always performed.

Decomposition:
- Package imem_arb_pkg holds:
  - DEPTH and AW defaults.
  - Requester ID enum (REQ_FETCH=0, REQ_LOAD=1).
  - Response record typedef: owner, err, is_write.
- Sub-module imem_arb_prio (natural to split out):
  - Inputs: f_valid, l_valid.
  - Contains the starvation counter.
  - Outputs: grant_f and grant_l (one-hot or zero).

Test Plan:
- Reset, then single fetch, with mem[0]=32'hFE420AE3:
  - f_addr=0 gives f_ready=1 in the same cycle.
  - Next cycle: f_rvalid=1, f_rdata=32'hFE420AE3, f_err=0.
- Loader write then fetch:
  - l_we=1, l_addr=0x8, l_wdata=0x00B62423, then f_addr=0x8 the next cycle.
  - Required: l_rvalid=1 with l_err=0, then f_rdata=0x00B62423.
- Contention with STARVE_MAX=4:
  - f_valid and l_valid held high for 10 cycles.
  - Required grant sequence: L,L,L,L,F,L,L,L,L,F.
- Error cases:
  - f_addr=0x2 gives f_err=1, f_rdata=0, mem_en=0.
  - l_addr=0x1000 gives l_err=1.
- Async reset mid-response:
  - Grant fetch, then assert rst before the next clk edge.
  - Required: f_rvalid stays 0 and all outputs are 0 while rst=1.
- With IMEM_ARB_LOCK_EN:
  - lock=1, loader write to 0x4 gives l_err=1 and mem_en=0.
  - A subsequent read of 0x4 returns the old value.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory port arbiter: size
// defaults, requester IDs, the response record and the address check.
package imem_arb_pkg;

    localparam int DEPTH_DEF      = 1024;
    localparam int AW_DEF         = 10;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } req_id_e;

    // Everything the response stage must remember about a granted request.
    typedef struct packed {
        req_id_e owner;
        logic    err;
        logic    is_write;
    } rsp_rec_t;

    // A byte address is unusable if it is not word aligned or its word
    // index falls outside the memory.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/imem_arb_prio.sv
// Loader-first priority with an anti-starvation counter for fetch.
// Grants are one-hot or zero and are held at zero while rst is high.
module imem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic f_valid,
    input  logic l_valid,
    output logic grant_f,
    output logic grant_l
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    // Pick the winner: loader unless fetch has waited STARVE_MAX loader grants.
    always_comb begin
        grant_f = 1'b0;
        grant_l = 1'b0;
        if (!rst) begin
            if (l_valid && !(f_valid && starved)) begin
                grant_l = 1'b1;
            end else if (f_valid) begin
                grant_f = 1'b1;
            end
        end
    end

    // Count loader wins while fetch is waiting; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!f_valid || grant_f) begin
            starve_cnt <= '0;
        end else if (grant_l && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch (read-only) and
// the boot/debug loader (read/write). One grant per cycle, read data one
// cycle after the grant, no response backpressure.
// Optional build macro IMEM_ARB_LOCK_EN adds a 'lock' input that turns
// loader writes into accepted-but-suppressed error responses.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AW         = AW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
`ifdef IMEM_ARB_LOCK_EN
    input  logic          lock,
`endif
    input  logic          f_valid,
    output logic          f_ready,
    input  logic [31:0]   f_addr,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    input  logic          l_valid,
    output logic          l_ready,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          l_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    // Handshake: a request transfers when valid & ready are both high in the
    // same cycle; ready depends only on valid and the arbitration state, and
    // requesters hold their fields stable until ready. Responses cannot stall.

    logic        grant_f;
    logic        grant_l;
    logic        any_grant;
    logic        is_write;
    logic        lock_hit;
    logic        req_err;
    logic [31:0] sel_addr;
    logic [31:0] rsp_data;
    rsp_rec_t    rsp_d;
    rsp_rec_t    rsp_q;
    logic        rsp_vld_q;

    imem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .f_valid (f_valid),
        .l_valid (l_valid),
        .grant_f (grant_f),
        .grant_l (grant_l)
    );

    assign any_grant = grant_f | grant_l;
    assign is_write  = grant_l & l_we;
    assign sel_addr  = grant_l ? l_addr : (grant_f ? f_addr : 32'h0);

`ifdef IMEM_ARB_LOCK_EN
    assign lock_hit = is_write & lock;
`else
    assign lock_hit = 1'b0;
`endif

    // Faulty requests are still accepted; they just never reach the memory.
    assign req_err   = any_grant & (addr_bad(sel_addr, 32'(DEPTH)) | lock_hit);

    assign f_ready   = grant_f;
    assign l_ready   = grant_l;
    assign mem_en    = any_grant & ~req_err;
    assign mem_we    = mem_en & is_write;
    assign mem_addr  = sel_addr[AW+1:2];
    assign mem_wdata = is_write ? l_wdata : 32'h0;

    // Describe the granted request for the response stage.
    always_comb begin
        rsp_d          = '0;
        rsp_d.owner    = grant_l ? REQ_LOAD : REQ_FETCH;
        rsp_d.err      = req_err;
        rsp_d.is_write = is_write;
    end

    // One-deep response register; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
        end else begin
            rsp_vld_q <= any_grant;
            rsp_q     <= rsp_d;
        end
    end

    // Route the memory data to the owner; errors and writes return zero.
    assign rsp_data = (rsp_vld_q && !rsp_q.err && !rsp_q.is_write) ? mem_rdata : 32'h0;
    assign f_rvalid = rsp_vld_q && (rsp_q.owner == REQ_FETCH);
    assign l_rvalid = rsp_vld_q && (rsp_q.owner == REQ_LOAD);
    assign f_rdata  = f_rvalid ? rsp_data : 32'h0;
    assign l_rdata  = l_rvalid ? rsp_data : 32'h0;
    assign f_err    = f_rvalid & rsp_q.err;
    assign l_err    = l_rvalid & rsp_q.err;

endmodule
